// File: rtl/updown_counter_p_if.sv
// Control/data bundle for updown_counter_p; compare signals exist only with COUNTER_CMP_EN.
interface updown_counter_p_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);
  logic [WIDTH-1:0]  Data_in;
  logic              Load;
  logic              CountEN;
  logic              INC;
  logic [STEP_W-1:0] Step;
  logic [WIDTH-1:0]  Limit;
  logic              Sat;
  logic              Flag_Clr;
  logic [WIDTH-1:0]  Output;
  logic              TC;
  logic              Ovf;
  logic              Unf;
`ifdef COUNTER_CMP_EN
  logic [WIDTH-1:0]  Cmp_in;
  logic              Cmp_Load;
  logic              Match;
`endif

`ifdef COUNTER_CMP_EN
  modport master (
    output Data_in, Load, CountEN, INC, Step, Limit, Sat, Flag_Clr, Cmp_in, Cmp_Load,
    input  Output, TC, Ovf, Unf, Match
  );
  modport slave (
    input  Data_in, Load, CountEN, INC, Step, Limit, Sat, Flag_Clr, Cmp_in, Cmp_Load,
    output Output, TC, Ovf, Unf, Match
  );
`else
  modport master (
    output Data_in, Load, CountEN, INC, Step, Limit, Sat, Flag_Clr,
    input  Output, TC, Ovf, Unf
  );
  modport slave (
    input  Data_in, Load, CountEN, INC, Step, Limit, Sat, Flag_Clr,
    output Output, TC, Ovf, Unf
  );
`endif
endinterface

// File: rtl/updown_counter_p.sv
// Parametrised up/down counter with runtime limit, wrap/saturate, TC pulse and sticky flags.
// Optional compare unit enabled by defining COUNTER_CMP_EN.
module updown_counter_p #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              Clear,
  updown_counter_p_if.slave bus
);
  localparam int unsigned CW = WIDTH + 1;

  logic [WIDTH-1:0]  count_q, count_d;
  logic              tc_q, tc_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [STEP_W-1:0] step;
  logic [CW-1:0]     lim_x, lim_p1, cnt_x, base, step_x, step_c, sum;
  logic              count_en;

  // Operands widened by one bit so Limit+1 and base+step never truncate.
  assign step     = bus.Step;
  assign lim_x    = {1'b0, bus.Limit};
  assign lim_p1   = lim_x + CW'(1);
  assign cnt_x    = {1'b0, count_q};
  assign base     = (cnt_x < lim_x) ? cnt_x : lim_x;
  assign step_x   = CW'(step);
  assign step_c   = (step_x > lim_p1) ? lim_p1 : step_x;
  assign sum      = base + step_c;
  assign count_en = bus.CountEN && (step != '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~bus.Flag_Clr;
    unf_d   = unf_q & ~bus.Flag_Clr;
    if (bus.Load) begin
      count_d = (bus.Data_in > bus.Limit) ? bus.Limit : bus.Data_in;
    end else if (count_en) begin
      if (bus.INC) begin
        if (sum > lim_x) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = bus.Sat ? bus.Limit : WIDTH'(sum - lim_p1);
        end else begin
          count_d = WIDTH'(sum);
        end
      end else begin
        if (base < step_c) begin
          tc_d    = 1'b1;
          unf_d   = 1'b1;
          count_d = bus.Sat ? '0 : WIDTH'(base + lim_p1 - step_c);
        end else begin
          count_d = WIDTH'(base - step_c);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Clear) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.Output = count_q;
  assign bus.TC     = tc_q;
  assign bus.Ovf    = ovf_q;
  assign bus.Unf    = unf_q;

`ifdef COUNTER_CMP_EN
  logic [WIDTH-1:0] cmp_q;

  // Compare register resets to all ones so Match is low after Clear.
  always_ff @(posedge clk) begin
    if (Clear) begin
      cmp_q <= '1;
    end else if (bus.Cmp_Load) begin
      cmp_q <= bus.Cmp_in;
    end
  end

  assign bus.Match = (count_q == cmp_q);
`endif
endmodule
